// File: rtl/accum_pkg.sv
// Shared types and defaults for the multi-operand accumulator and its adder core.
package accum_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } flags_t;

  // Fold one add's flag results into the sticky set; zero always tracks the latest sum.
  function automatic flags_t merge_flags(input flags_t cur, input logic carry,
                                         input logic ovf, input logic zero);
    flags_t nxt;
    nxt.carry    = cur.carry | carry;
    nxt.overflow = cur.overflow | ovf;
    nxt.zero     = zero;
    return nxt;
  endfunction

endpackage

// File: rtl/accum_32bit_add_flags_core.sv
// Combinational ripple-carry adder producing sum, unsigned carry-out and signed overflow.
module add_flags_core
  import accum_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_msb,
  output logic             ovf
);

  logic [WIDTH:0] carry_s;

  assign carry_s[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign carry_msb = carry_s[WIDTH];
  // Signed overflow: operands agree in sign but the result does not.
  assign ovf = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/accum_32bit.sv
// Streams COUNT operands over valid/ready, sums them with sticky carry/overflow,
// and presents the result with flags on a valid/ready output port.
module accum_32bit
  import accum_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_terms
);

  state_t           state_r;
  logic [WIDTH-1:0] acc_r;
  logic [CNT_W-1:0] remaining_r;
  logic [CNT_W-1:0] terms_r;
  flags_t           flags_r;

  logic [WIDTH-1:0] sum_s;
  logic             carry_s;
  logic             ovf_s;
  logic             beat_s;

  add_flags_core #(.WIDTH(WIDTH)) u_add (
    .a         (acc_r),
    .b         (in_data),
    .sum       (sum_s),
    .carry_msb (carry_s),
    .ovf       (ovf_s)
  );

  assign in_ready = (state_r == ACCUM);
  assign beat_s   = in_valid & in_ready;

  // FSM, accumulator, term counter and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= {WIDTH{1'b0}};
      remaining_r <= {CNT_W{1'b0}};
      terms_r     <= {CNT_W{1'b0}};
      flags_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r   <= {WIDTH{1'b0}};
            terms_r <= count;
            if (count != {CNT_W{1'b0}}) begin
              remaining_r <= count;
              flags_r     <= '0;
              state_r     <= ACCUM;
            end else begin
              remaining_r <= {CNT_W{1'b0}};
              flags_r     <= '{carry: 1'b0, overflow: 1'b0, zero: 1'b1};
              state_r     <= DONE;
            end
          end
        end
        ACCUM: begin
          if (beat_s) begin
            acc_r       <= sum_s;
            remaining_r <= remaining_r - {{(CNT_W-1){1'b0}}, 1'b1};
            flags_r     <= merge_flags(flags_r, carry_s, ovf_s, sum_s == {WIDTH{1'b0}});
            if (remaining_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
              state_r <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Zero is only reported once the run has finished, so a reset accumulator reads zero=0.
  assign busy         = (state_r != IDLE);
  assign out_valid    = (state_r == DONE);
  assign out_sum      = acc_r;
  assign out_carry    = flags_r.carry;
  assign out_overflow = flags_r.overflow;
  assign out_zero     = flags_r.zero & (state_r == DONE);
  assign out_terms    = terms_r;

endmodule

// File: tb/tb_accum_32bit.sv
// Directed and randomized checks of accum_32bit against a plain-arithmetic reference model.
module tb_accum_32bit;

  localparam int W  = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, busy, out_valid, out_ready;
  logic          out_carry, out_overflow, out_zero;
  logic [CW-1:0] count, out_terms;
  logic [W-1:0]  in_data, out_sum;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] ops[$];

  always #5 clk = ~clk;

  accum_32bit dut (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_overflow(out_overflow),
    .out_zero(out_zero), .out_terms(out_terms)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: total modulo 2**32, with carry/overflow judged on every partial add.
  task automatic model(output logic [31:0] s, output logic c, output logic v);
    s = 32'd0; c = 1'b0; v = 1'b0;
    foreach (ops[i]) begin
      logic [32:0] wide;
      longint      ss;
      wide = {1'b0, s} + {1'b0, ops[i]};
      ss   = longint'($signed(s)) + longint'($signed(ops[i]));
      c    = c | wide[32];
      v    = v | (ss > 64'sd2147483647) | (ss < -64'sd2147483648);
      s    = wide[31:0];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"},  64'(in_ready), 64'd0);
    check({tag, ".busy"},      64'(busy), 64'd0);
    check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".out_sum"},   64'(out_sum), 64'd0);
    check({tag, ".carry"},     64'(out_carry), 64'd0);
    check({tag, ".overflow"},  64'(out_overflow), 64'd0);
    check({tag, ".zero"},      64'(out_zero), 64'd0);
    check({tag, ".terms"},     64'(out_terms), 64'd0);
  endtask

  // One full run over the operands in ops; gaps, mid-run start, hold and handoff-start optional.
  task automatic run(input string tag, input int gap_max, input int hold,
                     input bit mid_start, input bit handoff_start);
    logic [31:0] es;
    logic        ec, ev;
    int          cnt;
    int          gaps;
    cnt = ops.size();
    model(es, ec, ev);
    in_valid = 1'b1; in_data = $urandom; tick;
    check({tag, ".idle_busy"}, 64'(busy), 64'd0);
    in_valid = 1'b0; start = 1'b1; count = CW'(cnt); tick;
    start = 1'b0;
    check({tag, ".busy"}, 64'(busy), 64'd1);
    foreach (ops[i]) begin
      gaps = (gap_max > 0) ? $urandom_range(1, gap_max) : 0;
      repeat (gaps) begin
        in_valid = 1'b0; in_data = $urandom;
        if (mid_start) begin start = 1'b1; count = 8'd5; end
        check({tag, ".gap_ready"}, 64'(in_ready), 64'd1);
        tick;
        start = 1'b0;
      end
      in_valid = 1'b1; in_data = ops[i];
      check({tag, ".beat_ready"}, 64'(in_ready), 64'd1);
      tick;
    end
    in_valid = 1'b0;
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".in_ready_done"}, 64'(in_ready), 64'd0);
    check({tag, ".sum"},      64'(out_sum), 64'(es));
    check({tag, ".carry"},    64'(out_carry), 64'(ec));
    check({tag, ".overflow"}, 64'(out_overflow), 64'(ev));
    check({tag, ".zero"},     64'(out_zero), 64'(es == 32'd0));
    check({tag, ".terms"},    64'(out_terms), 64'(cnt));
    repeat (hold) begin
      out_ready = 1'b0; in_valid = 1'b1; in_data = $urandom; start = 1'b1; count = 8'd7;
      tick;
      check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".hold_sum"},   64'(out_sum), 64'(es));
      check({tag, ".hold_flags"}, 64'({out_carry, out_overflow, out_zero}),
            64'({ec, ev, es == 32'd0}));
      check({tag, ".hold_terms"}, 64'(out_terms), 64'(cnt));
    end
    in_valid = 1'b0; start = 1'b0;
    out_ready = 1'b1;
    if (handoff_start) begin start = 1'b1; count = 8'd2; end
    tick;
    out_ready = 1'b0; start = 1'b0;
    check({tag, ".post_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".post_busy"},  64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; count = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick; tick;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick;

    ops = '{32'h5, 32'h7, 32'h10};               run("basic3", 0, 0, 1'b0, 1'b0);
    ops = '{32'hFFFF_FFFF, 32'h1};               run("wrap", 0, 1, 1'b0, 1'b0);
    ops = '{32'h7FFF_FFFF, 32'h1};               run("ovf", 0, 0, 1'b0, 1'b1);
    ops = '{32'h3};                              run("ovf_clear", 0, 0, 1'b0, 1'b0);
    ops.delete();                                run("count0", 0, 0, 1'b0, 1'b0);
    ops = '{32'h8000_0000, 32'h8000_0000};       run("neg_ovf", 0, 0, 1'b0, 1'b0);
    ops = '{32'h1111_1111, 32'h2222_2222, 32'h3, 32'hFFFF_FFF0};
    run("stress", 3, 5, 1'b1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int n;
      ops.delete();
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 3))
          0:       ops.push_back(32'hFFFF_FFFF);
          1:       ops.push_back(32'h7FFF_FFFF);
          default: ops.push_back($urandom);
        endcase
      end
      run($sformatf("rand%0d", r), r % 3, r % 4, r[0], r[1]);
    end

    ops.delete();
    for (int k = 0; k < 255; k++) ops.push_back($urandom);
    run("max_terms", 0, 0, 1'b0, 1'b0);

    // Abort a run after two of four beats.
    start = 1'b1; count = 8'd4; tick;
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h1234; tick;
    in_data = 32'h5678; tick;
    in_valid = 1'b0; rst = 1'b1; tick;
    rst = 1'b0;
    check_reset_outputs("abort");
    repeat (4) begin
      tick;
      check("abort.no_valid", 64'(out_valid), 64'd0);
    end
    ops = '{32'h9};                              run("after_abort", 0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
